// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared raster constants and scheduler state encoding
package raster_pkg;

  localparam int INT_W_DEF     = 20;
  localparam int SUBPIX_DEF    = 4;
  localparam int TILE_LOG2_DEF = 3;
  localparam int TW_DEF        = 10;
  localparam int W_DEF         = INT_W_DEF + SUBPIX_DEF + 1;

  // Right shift that turns a Q coordinate straight into a tile index.
  localparam int TILE_SHIFT    = SUBPIX_DEF + TILE_LOG2_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BBOX  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/tri_tile_sched_if.sv
// rtl/tri_tile_sched_if.sv - triangle-in / tile-out handshake bundle of the tile scheduler
interface tri_tile_sched_if #(
  parameter int W  = 25,
  parameter int TW = 10
) ();

  logic                tri_valid;
  logic                tri_ready;
  logic signed [W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
  logic [TW-1:0]       scr_tx_max;
  logic [TW-1:0]       scr_ty_max;
  logic                tile_valid;
  logic                tile_ready;
  logic signed [W-1:0] tile_x;
  logic signed [W-1:0] tile_y;
  logic                tile_first;
  logic                tile_last;
  logic                tri_done;
  logic                busy;

  modport master (
    input  tri_valid, vx0, vy0, vx1, vy1, vx2, vy2, scr_tx_max, scr_ty_max, tile_ready,
    output tri_ready, tile_valid, tile_x, tile_y, tile_first, tile_last, tri_done, busy
  );

  modport slave (
    output tri_valid, vx0, vy0, vx1, vy1, vx2, vy2, scr_tx_max, scr_ty_max, tile_ready,
    input  tri_ready, tile_valid, tile_x, tile_y, tile_first, tile_last, tri_done, busy
  );

endinterface

// File: rtl/tri_tile_sched_bbox.sv
// rtl/tri_tile_sched_bbox.sv - one-axis tile bounding box of three vertices, clamped to the scissor
module tile_bbox #(
  parameter int W     = 25,
  parameter int TW    = 10,
  parameter int SHIFT = 7
) (
  input  logic signed [W-1:0] v0_i,
  input  logic signed [W-1:0] v1_i,
  input  logic signed [W-1:0] v2_i,
  input  logic [TW-1:0]       scr_max_i,
  output logic [TW-1:0]       t_min_o,
  output logic [TW-1:0]       t_max_o,
  output logic                empty_o
);

  logic signed [W-1:0] t0, t1, t2;
  logic signed [W-1:0] mn, mx, mn_c, mx_c, scr_w;

  assign t0    = v0_i >>> SHIFT;
  assign t1    = v1_i >>> SHIFT;
  assign t2    = v2_i >>> SHIFT;
  assign scr_w = $signed({{(W-TW){1'b0}}, scr_max_i});

  // Compare at full width so a min far beyond the scissor cannot wrap back into range.
  always_comb begin
    mn = t0;
    mx = t0;
    if (t1 < mn) mn = t1;
    if (t2 < mn) mn = t2;
    if (t1 > mx) mx = t1;
    if (t2 > mx) mx = t2;
    mn_c = mn[W-1] ? '0 : mn;
    mx_c = mx[W-1] ? '0 : mx;
    if (mx_c > scr_w) mx_c = scr_w;
    empty_o = (mn_c > mx_c);
    t_min_o = mn_c[TW-1:0];
    t_max_o = mx_c[TW-1:0];
  end

endmodule

// File: rtl/tri_tile_sched.sv
// rtl/tri_tile_sched.sv - per-triangle row-major tile walker; TRI_TILE_SCHED_PERF_EN adds perf counters
module tri_tile_sched
  import raster_pkg::*;
#(
  parameter int INT_W     = INT_W_DEF,
  parameter int SUBPIX    = SUBPIX_DEF,
  parameter int W         = INT_W + SUBPIX + 1,
  parameter int TILE_LOG2 = TILE_LOG2_DEF,
  parameter int TW        = TW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef TRI_TILE_SCHED_PERF_EN
  output logic [31:0]        perf_tiles,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_tris,
`endif
  tri_tile_sched_if.master   bus
);

  localparam int SHIFT = SUBPIX + TILE_LOG2;

  sched_state_e        state_q;
  logic                tri_ready_q;
  logic signed [W-1:0] vx_q [3];
  logic signed [W-1:0] vy_q [3];
  logic [TW-1:0]       scr_tx_q, scr_ty_q;
  logic [TW-1:0]       tx_min_q, tx_max_q, ty_min_q, ty_max_q;
  logic [TW-1:0]       tx_q, ty_q, tx_d, ty_d;
  logic [TW-1:0]       bx_min, bx_max, by_min, by_max;
  logic                bx_empty, by_empty, at_last;

  tile_bbox #(.W(W), .TW(TW), .SHIFT(SHIFT)) u_bbox_x (
    .v0_i      (vx_q[0]),
    .v1_i      (vx_q[1]),
    .v2_i      (vx_q[2]),
    .scr_max_i (scr_tx_q),
    .t_min_o   (bx_min),
    .t_max_o   (bx_max),
    .empty_o   (bx_empty)
  );

  tile_bbox #(.W(W), .TW(TW), .SHIFT(SHIFT)) u_bbox_y (
    .v0_i      (vy_q[0]),
    .v1_i      (vy_q[1]),
    .v2_i      (vy_q[2]),
    .scr_max_i (scr_ty_q),
    .t_min_o   (by_min),
    .t_max_o   (by_max),
    .empty_o   (by_empty)
  );

  assign at_last = (tx_q == tx_max_q) && (ty_q == ty_max_q);

  always_comb begin
    tx_d = tx_q;
    ty_d = ty_q;
    if (tx_q < tx_max_q) begin
      tx_d = tx_q + TW'(1);
    end else begin
      tx_d = tx_min_q;
      ty_d = ty_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tri_ready_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      scr_tx_q <= '0;
      scr_ty_q <= '0;
      tx_min_q <= '0;
      tx_max_q <= '0;
      ty_min_q <= '0;
      ty_max_q <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tri_ready_q <= 1'b1;
          if (bus.tri_valid && tri_ready_q) begin
            vx_q[0]     <= bus.vx0;
            vx_q[1]     <= bus.vx1;
            vx_q[2]     <= bus.vx2;
            vy_q[0]     <= bus.vy0;
            vy_q[1]     <= bus.vy1;
            vy_q[2]     <= bus.vy2;
            scr_tx_q    <= bus.scr_tx_max;
            scr_ty_q    <= bus.scr_ty_max;
            tri_ready_q <= 1'b0;
            state_q     <= BBOX;
          end
        end
        BBOX: begin
          tx_min_q <= bx_min;
          tx_max_q <= bx_max;
          ty_min_q <= by_min;
          ty_max_q <= by_max;
          tx_q     <= bx_min;
          ty_q     <= by_min;
          state_q  <= (bx_empty || by_empty) ? DONE : ISSUE;
        end
        ISSUE: begin
          if (bus.tile_ready) begin
            if (at_last) begin
              state_q <= DONE;
            end else begin
              tx_q <= tx_d;
              ty_q <= ty_d;
            end
          end
        end
        DONE: begin
          // Ready is raised here so IDLE can accept on its very first cycle.
          tri_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tri_ready  = tri_ready_q;
  assign bus.tile_valid = (state_q == ISSUE);
  assign bus.tri_done   = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.tile_x     = W'(tx_q) << SHIFT;
  assign bus.tile_y     = W'(ty_q) << SHIFT;
  assign bus.tile_first = (state_q == ISSUE) && (tx_q == tx_min_q) && (ty_q == ty_min_q);
  assign bus.tile_last  = (state_q == ISSUE) && at_last;

`ifdef TRI_TILE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_tiles <= '0;
      perf_stall <= '0;
      perf_tris  <= '0;
    end else begin
      if (bus.tile_valid && bus.tile_ready)  perf_tiles <= perf_tiles + 32'd1;
      if (bus.tile_valid && !bus.tile_ready) perf_stall <= perf_stall + 32'd1;
      if (bus.tri_done)                      perf_tris  <= perf_tris + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tri_tile_sched.sv
// tb/tb_tri_tile_sched.sv - directed and random check of tri_tile_sched against a tile-list model
module tb_tri_tile_sched;
  import raster_pkg::*;

  localparam int W   = W_DEF;
  localparam int TW  = TW_DEF;
  localparam int TSZ = 1 << TILE_SHIFT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tri_tile_sched_if #(.W(W), .TW(TW)) bus ();

`ifdef TRI_TILE_SCHED_PERF_EN
  logic [31:0] perf_tiles, perf_stall, perf_tris;
`endif

  tri_tile_sched #(.W(W), .TW(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef TRI_TILE_SCHED_PERF_EN
    .perf_tiles (perf_tiles),
    .perf_stall (perf_stall),
    .perf_tris  (perf_tris),
`endif
    .bus        (bus)
  );

  typedef struct {
    int x;
    int y;
    bit first;
    bit last;
  } tile_t;

  tile_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Expected tile list: floor each vertex to a tile, take extents, clamp, enumerate row-major.
  task automatic build_exp(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int sx, input int sy);
    int ax[3];
    int ay[3];
    int mnx, mxx, mny, mxy;
    ax[0] = fdiv(x0, TSZ); ax[1] = fdiv(x1, TSZ); ax[2] = fdiv(x2, TSZ);
    ay[0] = fdiv(y0, TSZ); ay[1] = fdiv(y1, TSZ); ay[2] = fdiv(y2, TSZ);
    mnx = ax[0]; mxx = ax[0]; mny = ay[0]; mxy = ay[0];
    for (int i = 1; i < 3; i++) begin
      if (ax[i] < mnx) mnx = ax[i];
      if (ax[i] > mxx) mxx = ax[i];
      if (ay[i] < mny) mny = ay[i];
      if (ay[i] > mxy) mxy = ay[i];
    end
    if (mnx < 0) mnx = 0;
    if (mny < 0) mny = 0;
    if (mxx < 0) mxx = 0;
    if (mxy < 0) mxy = 0;
    if (mxx > sx) mxx = sx;
    if (mxy > sy) mxy = sy;
    exp_q.delete();
    if (mnx > mxx || mny > mxy) return;
    for (int ty = mny; ty <= mxy; ty++)
      for (int tx = mnx; tx <= mxx; tx++)
        exp_q.push_back('{tx * TSZ, ty * TSZ, (tx == mnx && ty == mny), (tx == mxx && ty == mxy)});
  endtask

  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int sx, input int sy);
    int n = 0;
    build_exp(x0, y0, x1, y1, x2, y2, sx, sy);
    while (bus.tri_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("tri_ready_wait", 64'(bus.tri_ready), 64'd1);
    bus.vx0 = W'(x0); bus.vy0 = W'(y0);
    bus.vx1 = W'(x1); bus.vy1 = W'(y1);
    bus.vx2 = W'(x2); bus.vy2 = W'(y2);
    bus.scr_tx_max = TW'(sx);
    bus.scr_ty_max = TW'(sy);
    bus.tri_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tri_valid = 1'b0;
  endtask

  // mode 0: ready always high, 1: 1,0,1,0..., 2: random. stop_after>0 returns after that many tiles.
  task automatic run_tri(input int mode, input int stop_after);
    int got = 0;
    int cyc = 0;
    int stalls = 0;
    int ntiles;
    bit r;
    tile_t e;
`ifdef TRI_TILE_SCHED_PERF_EN
    logic [31:0] p_tiles0, p_stall0, p_tris0;
    p_tiles0 = perf_tiles; p_stall0 = perf_stall; p_tris0 = perf_tris;
`endif
    ntiles = exp_q.size();
    @(negedge clk);
    chk("bbox_gap_valid", 64'(bus.tile_valid), 64'd0);
    chk("bbox_busy", 64'(bus.busy), 64'd1);
    chk("bbox_ready", 64'(bus.tri_ready), 64'd0);
    @(negedge clk);
    if (ntiles == 0) begin
      chk("empty_done", 64'(bus.tri_done), 64'd1);
      chk("empty_valid", 64'(bus.tile_valid), 64'd0);
    end else begin
      chk("first_latency", 64'(bus.tile_valid), 64'd1);
      while (exp_q.size() > 0 && cyc < 600) begin
        if (stop_after > 0 && got == stop_after) return;
        cyc++;
        e = exp_q[0];
        chk("tile_valid", 64'(bus.tile_valid), 64'd1);
        chk("tile_x", 64'(bus.tile_x), 64'(e.x));
        chk("tile_y", 64'(bus.tile_y), 64'(e.y));
        chk("tile_first", 64'(bus.tile_first), 64'(e.first));
        chk("tile_last", 64'(bus.tile_last), 64'(e.last));
        chk("early_done", 64'(bus.tri_done), 64'd0);
        if (mode == 0) r = 1'b1;
        else if (mode == 1) r = (cyc % 2) == 1;
        else r = 1'($urandom_range(0, 1));
        bus.tile_ready = r;
        if (bus.tile_valid === 1'b1 && !r) stalls++;
        if (bus.tile_valid === 1'b1 && r) begin
          void'(exp_q.pop_front());
          got++;
        end
        @(negedge clk);
      end
      if (cyc >= 600) chk("tile_timeout", 64'(exp_q.size()), 64'd0);
      chk("done_pulse", 64'(bus.tri_done), 64'd1);
      chk("done_valid", 64'(bus.tile_valid), 64'd0);
    end
`ifdef TRI_TILE_SCHED_PERF_EN
    chk("perf_tiles", 64'(perf_tiles - p_tiles0), 64'(ntiles));
    chk("perf_stall", 64'(perf_stall - p_stall0), 64'(stalls));
    chk("perf_tris", 64'(perf_tris - p_tris0), 64'd1);
`endif
    bus.tile_ready = 1'b1;
    @(negedge clk);
    chk("after_done_pulse", 64'(bus.tri_done), 64'd0);
    chk("after_done_ready", 64'(bus.tri_ready), 64'd1);
    chk("after_done_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.tri_ready), 64'd0);
    chk({tag, "_valid"}, 64'(bus.tile_valid), 64'd0);
    chk({tag, "_x"}, 64'(bus.tile_x), 64'd0);
    chk({tag, "_y"}, 64'(bus.tile_y), 64'd0);
    chk({tag, "_first"}, 64'(bus.tile_first), 64'd0);
    chk({tag, "_last"}, 64'(bus.tile_last), 64'd0);
    chk({tag, "_done"}, 64'(bus.tri_done), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
`ifdef TRI_TILE_SCHED_PERF_EN
    chk({tag, "_perf"}, 64'(perf_tiles | perf_stall | perf_tris), 64'd0);
`endif
  endtask

  initial begin
    int px[6];
    bus.tri_valid = 1'b0;
    bus.vx0 = '0; bus.vy0 = '0; bus.vx1 = '0; bus.vy1 = '0; bus.vx2 = '0; bus.vy2 = '0;
    bus.scr_tx_max = '0;
    bus.scr_ty_max = '0;
    bus.tile_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 64'(bus.tri_ready), 64'd1);

    send_tri(16, 16, 320, 32, 48, 272, 79, 59);
    run_tri(0, 0);

    send_tri(16, 16, 320, 32, 48, 272, 79, 59);
    run_tri(1, 0);

    send_tri(-80, -80, -16, -16, -48, -32, 79, 59);
    run_tri(0, 0);

    send_tri(720 * 16, 16, 767 * 16, 32, 740 * 16, 40, 79, 59);
    run_tri(0, 0);

    send_tri(144, 144, 144, 144, 144, 144, 79, 59);
    run_tri(0, 0);

    // Reset after the third tile of a 9-tile triangle.
    send_tri(16, 16, 320, 32, 48, 272, 79, 59);
    run_tri(0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_ready", 64'(bus.tri_ready), 64'd1);
    repeat (3) begin
      chk("midreset_no_done", 64'(bus.tri_done), 64'd0);
      @(negedge clk);
    end
    send_tri(144, 16, 400, 200, 300, 100, 79, 59);
    run_tri(0, 0);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 6; i++)
        px[i] = ($urandom_range(0, 140) - 20) * 16 + $urandom_range(0, 15);
      send_tri(px[0], px[1], px[2], px[3], px[4], px[5],
               $urandom_range(0, 12), $urandom_range(0, 12));
      run_tri(2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
